// File: rtl/hex_disp_pkg.sv
// Shared mode encoding and segment patterns for the HEX digit sequencer.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_LOAD   = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_e;

    localparam logic [6:0] PAT_ON  = 7'h2A;
    localparam logic [6:0] PAT_OFF = 7'h55;

    // Level of an unlit segment on the active-low HEX outputs.
    localparam logic SEG_BLANK = 1'b1;

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchroniser plus falling-edge detect for active-low push keys.
// Latency: press[i] is high for one cycle, two edges after key_n[i] falls; no backpressure.
module key_edge_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_key_n,
    output logic [W-1:0] o_press
);

    logic [W-1:0] r_sync1;
    logic [W-1:0] r_sync2;
    logic [W-1:0] r_armed;
    logic [1:0]   r_live;

    // A key only arms after a genuine high sample, so one held low across reset never fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_armed <= '0;
            r_live  <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_live  <= {r_live[0], 1'b1};
            r_armed <= ~o_press & (r_armed | (r_sync2 & {W{r_live[1]}}));
        end
    end

    assign o_press = r_armed & ~r_sync2;

endmodule

// File: rtl/hex_digit_sequencer.sv
// Registered seven-segment controller: DIRECT/LOAD/TOGGLE/SCROLL modes, optional blink (HEX_BLINK_EN).
// Latency: key fall to hex is 4 edges, sw_seg to hex is 2 edges; no backpressure.
module hex_digit_sequencer
    import hex_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SEG_W    = 7,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEG_W-1:0]          sw_seg,
    input  logic [1:0]                sw_mode,
    input  logic                      sw_inv,
    input  logic                      blink_en,
    input  logic [DIGITS-1:0]         key_n,
    output logic [DIGITS*SEG_W-1:0]   hex
);

    localparam int                HW      = DIGITS * SEG_W;
    localparam int                CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [HW-1:0]     r_seg_buf;
    logic [DIGITS-1:0] r_flag;
    logic              r_pause;
    logic [CNT_W-1:0]  r_cnt;
    logic [HW-1:0]     r_hex;

    logic [DIGITS-1:0] w_press;
    logic [HW-1:0]     w_rot;
    logic [HW-1:0]     w_src;
    logic              w_tick;
    logic              w_blank;
    mode_e             w_mode;

    assign w_mode = mode_e'(sw_mode);
    assign w_tick = (r_cnt == CNT_MAX);

    key_edge_sync #(.W(DIGITS)) u_keys (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key_n),
        .o_press (w_press)
    );

    generate
        if (DIGITS > 1) begin : g_rot
            assign w_rot = {r_seg_buf[HW-SEG_W-1:0], r_seg_buf[HW-1 -: SEG_W]};
        end else begin : g_hold
            assign w_rot = r_seg_buf;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_buf <= '0;
            r_flag    <= '0;
            r_pause   <= 1'b0;
        end else begin
            case (w_mode)
                MODE_DIRECT: r_seg_buf[SEG_W-1:0] <= sw_seg;
                MODE_LOAD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (w_press[i]) r_seg_buf[i*SEG_W +: SEG_W] <= sw_seg;
                    end
                end
                MODE_TOGGLE: r_flag <= r_flag ^ w_press;
                MODE_SCROLL: begin
                    if (w_press[0]) r_pause <= ~r_pause;
                    if (w_tick && !r_pause) r_seg_buf <= w_rot;
                end
            endcase
        end
    end

    always_comb begin
        w_src = r_seg_buf;
        if (w_mode == MODE_TOGGLE) begin
            for (int i = 0; i < DIGITS; i++) begin
                w_src[i*SEG_W +: SEG_W] = (r_flag[i] ^ sw_inv) ? SEG_W'(PAT_ON) : SEG_W'(PAT_OFF);
            end
        end
    end

`ifdef HEX_BLINK_EN
    logic r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_phase <= ~r_phase;
        end
    end

    assign w_blank = blink_en & r_phase;
`else
    logic w_unused_blink;
    assign w_unused_blink = blink_en;
    assign w_blank        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hex <= {HW{SEG_BLANK}};
        end else if (w_blank) begin
            r_hex <= {HW{SEG_BLANK}};
        end else begin
            r_hex <= ~w_src;
        end
    end

    assign hex = r_hex;

endmodule

// File: tb/tb_hex_digit_sequencer.sv
// Bench for hex_digit_sequencer (DIGITS=4, TICK_DIV=4): cycle model plus directed literal checks.
module tb_hex_digit_sequencer;

    localparam int DIGITS = 4;
    localparam int SEG_W  = 7;
    localparam int TDIV   = 4;
    localparam int HW     = DIGITS * SEG_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [SEG_W-1:0]  sw_seg;
    logic [1:0]        sw_mode;
    logic              sw_inv;
    logic              blink_en;
    logic [DIGITS-1:0] key_n;
    logic [HW-1:0]     hex;

    int checks = 0;
    int errors = 0;

    hex_digit_sequencer #(.DIGITS(DIGITS), .SEG_W(SEG_W), .TICK_DIV(TDIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_seg   (sw_seg),
        .sw_mode  (sw_mode),
        .sw_inv   (sw_inv),
        .blink_en (blink_en),
        .key_n    (key_n),
        .hex      (hex)
    );

    always #5 clk = ~clk;

    // Behavioural model: keys as a sample history, display as per-digit arrays.
    logic [SEG_W-1:0]  m_buf [DIGITS];
    logic [SEG_W-1:0]  m_old [DIGITS];
    logic              m_flag [DIGITS];
    logic              m_pause;
    int                m_cnt;
    logic              m_phase;
    logic [HW-1:0]     m_hex;
    logic [DIGITS-1:0] m_samp [$];
    logic [DIGITS-1:0] m_press;
    logic [HW-1:0]     m_exp;
    logic [SEG_W-1:0]  m_dig;
    logic              m_tick;
    int                m_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                m_buf[i]  = '0;
                m_flag[i] = 1'b0;
            end
            m_pause = 1'b0;
            m_cnt   = 0;
            m_phase = 1'b0;
            m_hex   = '1;
            m_samp.delete();
        end else begin
            m_samp.push_back(key_n);
            m_n     = m_samp.size();
            m_press = '0;
            if (m_n >= 4) m_press = m_samp[m_n-4] & ~m_samp[m_n-3];
            for (int i = 0; i < DIGITS; i++) begin
                if (sw_mode == 2'd2) m_dig = (m_flag[i] ^ sw_inv) ? 7'h2A : 7'h55;
                else                 m_dig = m_buf[i];
                m_exp[i*SEG_W +: SEG_W] = ~m_dig;
            end
`ifdef HEX_BLINK_EN
            if (blink_en && m_phase) m_exp = '1;
`endif
            m_hex  = m_exp;
            m_tick = (m_cnt == TDIV - 1);
            case (sw_mode)
                2'd0: m_buf[0] = sw_seg;
                2'd1: for (int i = 0; i < DIGITS; i++) if (m_press[i]) m_buf[i] = sw_seg;
                2'd2: for (int i = 0; i < DIGITS; i++) if (m_press[i]) m_flag[i] = ~m_flag[i];
                default: begin
                    if (m_tick && !m_pause) begin
                        for (int i = 0; i < DIGITS; i++) m_old[i] = m_buf[i];
                        for (int i = 0; i < DIGITS; i++) m_buf[i] = m_old[(i + DIGITS - 1) % DIGITS];
                    end
                    if (m_press[0]) m_pause = ~m_pause;
                end
            endcase
            m_cnt = m_tick ? 0 : m_cnt + 1;
            if (m_tick) m_phase = ~m_phase;
        end
    end

    task automatic check(input string name, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) check("model_hex", hex, m_hex);

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_change(input int limit, output int cycles);
        logic [HW-1:0] prev;
        prev   = hex;
        cycles = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (hex !== prev) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic load_digit(input int d, input logic [SEG_W-1:0] v);
        sw_seg   = v;
        key_n[d] = 1'b0;
        cyc(3);
        key_n    = '1;
        cyc(3);
    endtask

    int c;
    int nchg;
    int nblank;
    logic [HW-1:0] prev_hex;

    initial begin
        rst = 1'b1; sw_seg = '0; sw_mode = 2'd0; sw_inv = 1'b0; blink_en = 1'b0; key_n = '1;
        cyc(2);
        check("reset_hex", hex, 28'hFFFFFFF);
        rst = 1'b0;
        cyc(10);
        check("idle_blank", hex, 28'hFFFFFFF);

        // DIRECT
        sw_seg = 7'h3F;
        cyc(1);
        check("direct_1edge", hex, 28'hFFFFFFF);
        cyc(1);
        check("direct_2edge", hex, {7'h7F, 7'h7F, 7'h7F, 7'h40});

        // LOAD: one 5-cycle press, then a double press
        sw_mode = 2'd1; sw_seg = 7'h06; key_n[2] = 1'b0;
        cyc(3);
        check("load_3edge", hex, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        cyc(1);
        check("load_4edge", hex, {7'h7F, 7'h79, 7'h7F, 7'h40});
        cyc(1);
        key_n = '1;
        sw_seg = 7'h5B;
        cyc(2);
        key_n = 4'b0110;
        cyc(4);
        check("load_dual", hex, {7'h24, 7'h79, 7'h7F, 7'h24});
        key_n = '1;
        cyc(3);

        // TOGGLE
        sw_mode = 2'd2;
        cyc(1);
        check("toggle_init", hex, {7'h2A, 7'h2A, 7'h2A, 7'h2A});
        key_n[1] = 1'b0;
        cyc(4);
        check("toggle_key1", hex, {7'h2A, 7'h2A, 7'h55, 7'h2A});
        key_n = '1;
        sw_inv = 1'b1;
        cyc(1);
        check("toggle_inv", hex, {7'h55, 7'h55, 7'h2A, 7'h55});
        sw_inv = 1'b0;
        cyc(2);

        // SCROLL
        sw_mode = 2'd1;
        load_digit(3, 7'h01);
        load_digit(2, 7'h02);
        load_digit(1, 7'h04);
        load_digit(0, 7'h08);
        sw_mode = 2'd3;
        cyc(1);
        check("scroll_start", hex, {7'h7E, 7'h7D, 7'h7B, 7'h77});
        wait_change(8, c);
        check_int("scroll_first_seen", (c > 0) ? 1 : 0, 1);
        check("scroll_rot1", hex, {7'h7D, 7'h7B, 7'h77, 7'h7E});
        wait_change(8, c);
        check_int("scroll_period", c, 4);
        check("scroll_rot2", hex, {7'h7B, 7'h77, 7'h7E, 7'h7D});

        key_n[0] = 1'b0;
        cyc(2);
        key_n = '1;
        cyc(6);
        nchg = 0;
        prev_hex = hex;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (hex !== prev_hex) nchg++;
            prev_hex = hex;
        end
        check_int("pause_frozen", nchg, 0);
        key_n[0] = 1'b0;
        cyc(2);
        key_n = '1;
        wait_change(12, c);
        check_int("pause_resume", (c > 0) ? 1 : 0, 1);

        // Asynchronous reset mid-scroll, with key 3 held low across release
        #2 rst = 1'b1;
        #1 check("rst_async_blank", hex, 28'hFFFFFFF);
        key_n[3] = 1'b0; sw_mode = 2'd1; sw_seg = 7'h7F;
        cyc(2);
        rst = 1'b0;
        cyc(8);
        check("held_key_no_press", hex, 28'hFFFFFFF);
        key_n = '1;
        cyc(3);
        key_n[3] = 1'b0;
        cyc(4);
        check("repress_after_reset", hex, {7'h00, 7'h7F, 7'h7F, 7'h7F});
        key_n = '1;
        cyc(2);

        // Blink
        sw_mode = 2'd0; sw_seg = 7'h3F; blink_en = 1'b1;
        cyc(4);
        nblank = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (hex === 28'hFFFFFFF) nblank++;
        end
`ifdef HEX_BLINK_EN
        check_int("blink_blank_cycles", nblank, 12);
`else
        check_int("blink_blank_cycles", nblank, 0);
`endif
        blink_en = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_digit_sequencer.md
# hex_digit_sequencer

Registered, parametrised seven-segment display controller for the board's HEX digits, driven from the slide switches and push keys. It generalises the combinational key/switch-to-segment lab driver to DIGITS digits. It adds synchronised, edge-detected keys, per-digit segment storage, four operating modes including timed scrolling, and an optional blink. It sits directly between the board I/O pins and the HEX outputs.

## Interface
- DIGITS, 4: number of seven-segment digits driven (1..8).
- SEG_W, 7: segments per digit.
- TICK_DIV, 25_000_000: clk cycles per scroll/blink tick (≥2).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset; one clock; polarity and synchronicity fixed.
- sw_seg  in  SEG_W  segment pattern from switches, active-high (1 = segment lit).
- sw_mode  in  2  operating mode: 0 DIRECT, 1 LOAD, 2 TOGGLE, 3 SCROLL.
- sw_inv  in  1  inverts per-digit flag selection in TOGGLE.
- blink_en  in  1  blink request; ignored unless HEX_BLINK_EN is defined.
- key_n  in  DIGITS  push keys, active-low, asynchronous to clk.
- hex  out  DIGITS*SEG_W  segment outputs, active-low; digit i at [i*SEG_W +: SEG_W].

## Operation
- Keys: two-flop synchroniser per bit, then falling-edge detect producing a one-cycle press[i]. Held keys give exactly one press. Simultaneous presses on several keys all act in the same cycle.
- State: seg_buf[DIGITS] (SEG_W each), flag[DIGITS], pause, tick counter, hex register.
- Constants: PAT_ON = 7'h2A, PAT_OFF = 7'h55.
- DIRECT: every cycle seg_buf[0] <= sw_seg. Other digits hold. Keys are ignored.
- LOAD: press[i] → seg_buf[i] <= sw_seg.
- TOGGLE: press[i] → flag[i] <= ~flag[i]. Digit i displays PAT_ON if flag[i]^sw_inv, else PAT_OFF. seg_buf is not modified.
- SCROLL: on each tick, when pause=0, seg_buf rotates up: digit i <= digit i-1, and digit 0 <= digit DIGITS-1. press[0] toggles pause. Other keys are ignored. With DIGITS=1, rotation is a hold.
- Display source is seg_buf in DIRECT, LOAD and SCROLL, and the flag patterns in TOGGLE. Output: hex <= ~source.
- Mode change takes effect on the next cycle. seg_buf, flag and pause are preserved across modes.
- Tick counter: free-running, 0..TICK_DIV-1. The tick pulse fires at TICK_DIV-1, then the counter wraps to 0. It is not reset by mode change.

## Timing
- Reset values: seg_buf=0, flag=0, pause=0, counter=0, synchroniser flops=1 (released), blink phase=0. hex is all ones (all digits blank).
- key_n fall → hex change on the 4th rising clk edge (2 sync, 1 state update, 1 output register).
- sw_seg change in DIRECT → hex digit 0 updates on the 2nd edge.
- Tick → rotated hex on the following edge.
- Key press during reset is lost. A key held low across reset release produces no press until it is released and pressed again.
- Reset asserted mid-scroll blanks hex immediately (asynchronously).

## Configuration
- HEX_BLINK_EN defined:
  - A phase bit toggles on every tick.
  - While blink_en=1 and phase=1, hex is driven all ones at the output register.
  - blink_en=0 clears nothing; phase keeps running.
- HEX_BLINK_EN undefined: no phase register, blink_en is unconnected, and hex always shows the source.

## Structure
- Package hex_disp_pkg:
  - mode enum (MODE_DIRECT, MODE_LOAD, MODE_TOGGLE, MODE_SCROLL);
  - PAT_ON and PAT_OFF;
  - SEG_BLANK.
- Sub-module key_edge_sync (parameter W): synchroniser plus falling-edge detect, outputs press[W-1:0]. Instantiated once with W=DIGITS.

## Test plan
- Reset with DIGITS=4 → hex = 28'hFFFFFFF. It stays all ones for 10 cycles with mode 0 and sw_seg=0.
- DIRECT, sw_seg=7'h3F → hex[6:0]=7'h40 two edges later. Upper digits remain 7'h7F.
- LOAD, sw_seg=7'h06, pulse key_n[2] low 5 cycles → hex[20:14]=7'h79 on the 4th edge after the fall. Exactly one load occurs. Pressing key_n[0] and key_n[3] in the same cycle with sw_seg=7'h5B loads both.
- TOGGLE, sw_inv=0, one press on key 1 → digit 1 shows ~7'h2A=7'h55; others show ~7'h55=7'h2A. Setting sw_inv=1 swaps all digits the next edge.
- SCROLL, TICK_DIV=4, seg_buf={7'h01,7'h02,7'h04,7'h08} (digit 3..0) → every 4 cycles the content rotates up by one digit. A key 0 press freezes the rotation; a second press resumes it. Asserting rst mid-rotation blanks hex immediately.
- HEX_BLINK_EN, TICK_DIV=4, blink_en=1 → hex alternates between the source and all ones every 4 cycles. With the macro undefined, hex is steady.
